// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit_if : start/busy/done handshake and HI/LO access for muldiv_unit
// Revision 1.0
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, wr_hi, wr_lo, wdata,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, wr_hi, wr_lo, wdata,
      output busy, done, div_zero, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit : iterative multu/mult/divu/div engine with HI/LO registers.
// Optional signed support via MULDIV_SIGNED_EN.  Revision 1.0
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;
`ifdef MULDIV_SIGNED_EN
   logic               neg_a_q, neg_a_d;
   logic               neg_b_q, neg_b_d;
`else
   logic               op_sign_unused;
   assign op_sign_unused = bus.op[0];
`endif

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   rem;
   logic               qbit;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
`endif
      sum      = '0;
      shifted  = '0;
      diff     = '0;
      rem      = '0;
      qbit     = 1'b0;
      prod     = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_CALC;
               busy_d   = 1'b1;
               cnt_d    = '0;
               acc_d    = '0;
               is_div_d = bus.op[1];
`ifdef MULDIV_SIGNED_EN
               neg_a_d  = bus.op[0] & bus.a[WIDTH-1];
               neg_b_d  = bus.op[0] & bus.b[WIDTH-1];
               a_d      = neg_a_d ? -bus.a : bus.a;
               b_d      = neg_b_d ? -bus.b : bus.b;
`else
               a_d      = bus.a;
               b_d      = bus.b;
`endif
            end else begin
               if (bus.wr_hi) hi_d = bus.wdata;
               if (bus.wr_lo) lo_d = bus.wdata;
            end
         end

         S_CALC: begin
            if (!is_div_q) begin
               // Upper half accumulates; product bits shift out into the lower half
               sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){b_q[0]}});
               acc_d = {sum, acc_q[WIDTH-1:1]};
               b_d   = b_q >> 1;
            end else begin
               // Upper half is the partial remainder, lower half collects quotient bits
               shifted = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
               diff    = shifted - {1'b0, b_q};
               qbit    = ~diff[WIDTH];
               rem     = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
               acc_d   = {rem, acc_q[WIDTH-2:0], qbit};
               a_d     = a_q << 1;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = S_FIXUP;
         end

         S_FIXUP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (!is_div_q) begin
               prod = acc_q;
`ifdef MULDIV_SIGNED_EN
               if (neg_a_q ^ neg_b_q) prod = -acc_q;
`endif
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else begin
               // A zero divisor leaves quotient all ones and remainder equal to the dividend
               dz_d = (b_q == '0);
               lo_d = acc_q[WIDTH-1:0];
               hi_d = acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
               if ((neg_a_q ^ neg_b_q) && !dz_d) lo_d = -acc_q[WIDTH-1:0];
               if (neg_a_q) hi_d = -acc_q[2*WIDTH-1:WIDTH];
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
`ifdef MULDIV_SIGNED_EN
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
`endif
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It replaces the combinational multu/HI/LO path with a parametrised sequential engine supporting multu, mult, divu and div, plus mthi/mtlo writes. It uses a start/busy/done handshake, so the controller stalls the pipeline while `busy` is high. `hi` and `lo` feed the mfhi/mflo result mux.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: launch operation; sampled only in IDLE.
- `op` in 2: operation, sampled with `start`; 00 multu, 01 mult, 10 divu, 11 div.
- `a` in WIDTH: rs operand (multiplicand / dividend), sampled with `start`.
- `b` in WIDTH: rt operand (multiplier / divisor), sampled with `start`.
- `wr_hi` in 1: mthi strobe.
- `wr_lo` in 1: mtlo strobe.
- `wdata` in WIDTH: mthi/mtlo data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; results are valid on `hi`/`lo`.
- `div_zero` out 1: valid with `done`; set when a divide had `b` == 0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States and transitions:
  - IDLE: on `start` -> CALC.
  - CALC: WIDTH iterations -> FIXUP.
  - FIXUP: -> IDLE.
- Start capture, in IDLE with `start`=1:
  - Latch `op`.
  - Signed ops: latch magnitudes of `a` and `b`, plus result sign flags.
  - Clear the iteration counter and the 2·WIDTH accumulator.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, unsigned magnitudes.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- FIXUP:
  - Apply sign correction and write results to `hi`/`lo`.
  - Multiply: product negated if operand signs differ; `hi` = upper half, `lo` = lower half.
  - Divide: `lo` = quotient, `hi` = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (divu or div): `lo` = all ones, `hi` = `a` as captured, no sign correction, `div_zero`=1.
- Signed overflow, div of −2^(WIDTH−1) by −1: `lo` = −2^(WIDTH−1), `hi` = 0, `div_zero`=0.
- mthi/mtlo: in IDLE with `start`=0, `wr_hi` loads `hi` from `wdata` and `wr_lo` loads `lo`, at the next edge. Both strobes may be asserted together.
- Dropped inputs:
  - `start` while busy is ignored.
  - `wr_hi`/`wr_lo` while busy are ignored.
  - `start` together with `wr_*` in IDLE: `start` wins and the writes are dropped.
- `hi`/`lo` hold their previous values throughout CALC; no partial results are visible.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0.
- Reset mid-operation aborts at the next edge with the same values.
- Edge E0 samples `start`.
  - `busy`=1 from after E0.
  - CALC runs over edges E1..E_WIDTH.
  - FIXUP edge is E_WIDTH+1: `hi`/`lo` update, `done`=1, `div_zero` valid, `busy`=0.
- Total latency: WIDTH+1 edges after the start edge (33 for WIDTH=32).
- `done` and `div_zero` last exactly one cycle.
- A new `start` may be presented in the `done` cycle; back-to-back throughput is WIDTH+1 cycles.
- mthi/mtlo latency: 1 edge.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - Ops 01 and 11 are signed, as above.
- `MULDIV_SIGNED_EN` undefined:
  - Sign-capture and FIXUP negation logic is removed.
  - Op 01 executes as multu and op 11 as divu.
  - The signed-overflow rule does not apply.
  - FIXUP still takes one cycle, so timing is identical.

## Test plan
All scenarios use WIDTH=32.
1. Reset, then multu a=30, b=31 -> `done` pulse 33 edges after start; `hi`=0, `lo`=930; `busy` high for exactly 33 cycles.
2. mult a=−3, b=5 -> `hi`=FFFFFFFF, `lo`=FFFFFFF1. Without `MULDIV_SIGNED_EN`: `hi`=00000004, `lo`=FFFFFFF1.
3. divu a=100, b=7 -> `lo`=14, `hi`=2. div a=−7, b=2 -> `lo`=FFFFFFFD, `hi`=FFFFFFFF. div a=80000000, b=FFFFFFFF -> `lo`=80000000, `hi`=0.
4. divu a=1234, b=0 -> `lo`=FFFFFFFF, `hi`=1234, `div_zero`=1 for one cycle.
5. mthi 0xDEAD with mtlo 0xBEEF in the same cycle -> both registers updated next edge. During a multu, pulse `start` (op=divu) and `wr_lo` -> both ignored; the multu result is unchanged.
6. Assert `reset` at CALC iteration 10 -> next edge `busy`=0, `hi`=`lo`=0, no `done`. A fresh multu afterwards completes normally.
